// File: rtl/mem_burst_stream_writer.sv
// Stream-to-DDR write-channel master: buffers stream words and issues address-incrementing write bursts.
// Optional macro MEM_WR_FLUSH_EN: frame_end flushes the residual (<BURST_LEN) words as a short burst.
//
// state | meaning
// IDLE  | no burst outstanding; waiting for a full burst (or a flush) in the FIFO
// REQ   | wr_burst_req held; controller pops words until wr_burst_finish
module mem_burst_stream_writer #(
  parameter int MEM_DATA_BITS = 32,
  parameter int BURST_LEN     = 128,
  parameter int FIFO_DEPTH    = 512,
  parameter int ADDR_BITS     = 27
) (
  input  logic                          mem_clk,
  input  logic                          rst_n,
  input  logic [ADDR_BITS-1:0]          base_addr,
  input  logic                          frame_start,
  input  logic                          frame_end,
  input  logic                          din_valid,
  input  logic [MEM_DATA_BITS-1:0]      din,
  output logic                          wr_burst_req,
  output logic [9:0]                    wr_burst_len,
  output logic [ADDR_BITS-1:0]          wr_burst_addr,
  input  logic                          wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0]      wr_burst_data,
  input  logic                          wr_burst_finish,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BURST_C = (AW+1)'(BURST_LEN);
  localparam logic [9:0]  LEN_C   = 10'(BURST_LEN);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                   state;
  logic [AW:0]              wr_ptr;
  logic [AW:0]              rd_ptr;
  logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [ADDR_BITS-1:0]     addr_ptr;
  logic [ADDR_BITS-1:0]     pend_base;
  logic                     pending;

  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        in_req;
  logic        start_now;
  logic        hold_drop;
  logic        push;
  logic        pop;
  logic        finish;
  logic        reload;

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign in_req     = (state == REQ);
  assign start_now  = frame_start && !in_req;
  // a frame_start during a burst drops pushes from its own cycle until the burst ends
  assign hold_drop  = pending || (in_req && frame_start);
  assign push       = din_valid && (start_now || (!full && !hold_drop));
  assign pop        = in_req && wr_burst_data_req && !empty;
  assign finish     = in_req && wr_burst_finish;
  assign reload     = finish && (pending || frame_start);

  assign fifo_count = count;
  assign busy       = in_req || !empty;

  always_ff @(posedge mem_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr_burst_data <= '0;
    end else begin
      if (pop) begin
        wr_burst_data <= mem[rd_ptr[AW-1:0]];
      end
      if (start_now) begin
        // flush keeps a same-cycle word as the first of the new frame
        rd_ptr <= wr_ptr;
        wr_ptr <= wr_ptr + {{AW{1'b0}}, push};
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (reload) begin
          rd_ptr <= wr_ptr;
        end else if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

`ifdef MEM_WR_FLUSH_EN
  logic flush_flag;
  logic burst_partial;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_burst_req  <= 1'b0;
      wr_burst_len  <= '0;
      wr_burst_addr <= '0;
      addr_ptr      <= '0;
      pend_base     <= '0;
      pending       <= 1'b0;
      overflow      <= 1'b0;
`ifdef MEM_WR_FLUSH_EN
      flush_flag    <= 1'b0;
      burst_partial <= 1'b0;
`endif
    end else begin
      if (din_valid && full && !start_now && !hold_drop) begin
        overflow <= 1'b1;
      end
`ifdef MEM_WR_FLUSH_EN
      if (frame_end) begin
        flush_flag <= 1'b1;
      end else if (start_now || reload || empty || (finish && burst_partial)) begin
        flush_flag <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (frame_start) begin
            addr_ptr <= base_addr;
            overflow <= 1'b0;
          end else if (count >= BURST_C) begin
            state         <= REQ;
            wr_burst_req  <= 1'b1;
            wr_burst_len  <= LEN_C;
            wr_burst_addr <= addr_ptr;
`ifdef MEM_WR_FLUSH_EN
            burst_partial <= 1'b0;
          end else if (flush_flag && !empty) begin
            // length is a snapshot; later pushes wait for the next burst
            state         <= REQ;
            wr_burst_req  <= 1'b1;
            wr_burst_len  <= 10'(count);
            wr_burst_addr <= addr_ptr;
            burst_partial <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (frame_start) begin
            pending   <= 1'b1;
            pend_base <= base_addr;
          end
          if (wr_burst_finish) begin
            state        <= IDLE;
            wr_burst_req <= 1'b0;
            if (pending || frame_start) begin
              addr_ptr <= frame_start ? base_addr : pend_base;
              pending  <= 1'b0;
              overflow <= 1'b0;
            end else begin
              addr_ptr <= addr_ptr + ADDR_BITS'(wr_burst_len);
            end
          end
        end
        default: begin
          state        <= IDLE;
          wr_burst_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_stream_writer.sv
// Directed bench for mem_burst_stream_writer: vector table of frames plus hand-written corner sequences.
module tb_mem_burst_stream_writer;

  logic        mem_clk;
  logic        rst_n;
  logic [26:0] base_addr;
  logic        frame_start;
  logic        frame_end;
  logic        din_valid;
  logic [31:0] din;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [26:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [31:0] wr_burst_data;
  logic        wr_burst_finish;
  logic        busy;
  logic        overflow;
  logic [9:0]  fifo_count;

  mem_burst_stream_writer dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .base_addr(base_addr),
    .frame_start(frame_start), .frame_end(frame_end),
    .din_valid(din_valid), .din(din),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish), .busy(busy), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int errors = 0;

  logic        ctrl_en = 1'b0;
  logic [26:0] addr_q[$];
  logic [9:0]  len_q[$];
  logic [31:0] rx_q[$];

  typedef struct packed {
    logic [26:0] base;
    logic [31:0] first;
    logic [15:0] nwords;
    logic [1:0]  nb;
    logic [26:0] addr0;
    logic [26:0] addr1;
    logic [9:0]  len0;
    logic [9:0]  len1;
    logic [9:0]  resid;
  } vec_t;

  vec_t vec [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic clear_q();
    addr_q.delete();
    len_q.delete();
    rx_q.delete();
  endtask

  task automatic pulse_start(input logic [26:0] b);
    base_addr   = b;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic push_words(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      din       = first + 32'(i);
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_req(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (wr_burst_req !== val && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(wr_burst_req), 64'(val));
  endtask

  // controller model: grants immediately, pops back-to-back, then pulses finish
  initial begin
    int nlen;
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b0;
    forever begin
      tick();
      if (ctrl_en && rst_n && wr_burst_req) begin
        addr_q.push_back(wr_burst_addr);
        len_q.push_back(wr_burst_len);
        nlen = int'(wr_burst_len);
        for (int k = 0; k < nlen; k++) begin
          wr_burst_data_req = 1'b1;
          tick();
          rx_q.push_back(wr_burst_data);
        end
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b1;
        tick();
        wr_burst_finish   = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_words;
    rst_n       = 1'b0;
    base_addr   = '0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    din_valid   = 1'b0;
    din         = '0;

    vec[0] = '{base: 27'h1000, first: 32'd0, nwords: 16'd256, nb: 2'd2,
               addr0: 27'h1000, addr1: 27'h1080, len0: 10'd128, len1: 10'd128, resid: 10'd0};
    vec[1] = '{base: 27'h7FFFF80, first: 32'd3000, nwords: 16'd256, nb: 2'd2,
               addr0: 27'h7FFFF80, addr1: 27'h0, len0: 10'd128, len1: 10'd128, resid: 10'd0};
`ifdef MEM_WR_FLUSH_EN
    vec[2] = '{base: 27'h40, first: 32'd5000, nwords: 16'd200, nb: 2'd2,
               addr0: 27'h40, addr1: 27'hC0, len0: 10'd128, len1: 10'd72, resid: 10'd0};
`else
    vec[2] = '{base: 27'h40, first: 32'd5000, nwords: 16'd200, nb: 2'd1,
               addr0: 27'h40, addr1: 27'h0, len0: 10'd128, len1: 10'd0, resid: 10'd72};
`endif

    repeat (3) tick();
    check("rst req",   64'(wr_burst_req),  64'd0);
    check("rst len",   64'(wr_burst_len),  64'd0);
    check("rst addr",  64'(wr_burst_addr), 64'd0);
    check("rst data",  64'(wr_burst_data), 64'd0);
    check("rst busy",  64'(busy),          64'd0);
    check("rst ovf",   64'(overflow),      64'd0);
    check("rst count", 64'(fifo_count),    64'd0);
    rst_n = 1'b1;
    tick();

    for (int s = 0; s < 3; s++) begin
      clear_q();
      ctrl_en = 1'b1;
      pulse_start(vec[s].base);
      push_words(vec[s].first, int'(vec[s].nwords));
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      repeat (400) tick();
      check($sformatf("v%0d nbursts", s), 64'(addr_q.size()), 64'(vec[s].nb));
      if (addr_q.size() > 0) begin
        check($sformatf("v%0d addr0", s), 64'(addr_q[0]), 64'(vec[s].addr0));
        check($sformatf("v%0d len0", s),  64'(len_q[0]),  64'(vec[s].len0));
      end
      if (vec[s].nb == 2'd2 && addr_q.size() > 1) begin
        check($sformatf("v%0d addr1", s), 64'(addr_q[1]), 64'(vec[s].addr1));
        check($sformatf("v%0d len1", s),  64'(len_q[1]),  64'(vec[s].len1));
      end
      exp_words = int'(vec[s].len0) + int'(vec[s].len1);
      check($sformatf("v%0d nwords", s), 64'(rx_q.size()), 64'(exp_words));
      for (int w = 0; w < exp_words && w < rx_q.size(); w++) begin
        check($sformatf("v%0d data[%0d]", s, w), 64'(rx_q[w]), 64'(vec[s].first + 32'(w)));
      end
      check($sformatf("v%0d hold data", s), 64'(wr_burst_data),
            64'(vec[s].first + 32'(exp_words) - 32'd1));
      check($sformatf("v%0d resid", s), 64'(fifo_count), 64'(vec[s].resid));
      check($sformatf("v%0d ovf", s),   64'(overflow),   64'd0);
    end

    // 127 words must not request; the 128th raises the request within 2 cycles
    clear_q();
    ctrl_en = 1'b0;
    pulse_start(27'h0);
    push_words(32'd0, 127);
    repeat (5) tick();
    check("b127 req",   64'(wr_burst_req), 64'd0);
    check("b127 count", 64'(fifo_count),   64'd127);
    check("b127 busy",  64'(busy),         64'd1);
    push_words(32'd127, 1);
    wait_req(1'b1, 2, "b128 req rise");
    check("b128 len",  64'(wr_burst_len),  64'd128);
    check("b128 addr", 64'(wr_burst_addr), 64'h0);
    ctrl_en = 1'b1;
    repeat (200) tick();
    check("b128 drained", 64'(rx_q.size()), 64'd128);
    check("b128 count",   64'(fifo_count),  64'd0);

    // controller stalls while 600 words arrive into a 512-word FIFO
    clear_q();
    ctrl_en = 1'b0;
    pulse_start(27'h3000);
    push_words(32'd1000, 600);
    check("ovf count", 64'(fifo_count),   64'd512);
    check("ovf flag",  64'(overflow),     64'd1);
    check("ovf req",   64'(wr_burst_req), 64'd1);
    ctrl_en = 1'b1;
    repeat (650) tick();
    check("ovf nbursts", 64'(addr_q.size()), 64'd4);
    for (int b = 0; b < 4 && b < addr_q.size(); b++) begin
      check($sformatf("ovf addr%0d", b), 64'(addr_q[b]), 64'(27'h3000 + 27'(b * 128)));
    end
    check("ovf nwords", 64'(rx_q.size()), 64'd512);
    for (int w = 0; w < 512 && w < rx_q.size(); w++) begin
      check($sformatf("ovf data[%0d]", w), 64'(rx_q[w]), 64'(32'd1000 + 32'(w)));
    end
    check("ovf sticky", 64'(overflow), 64'd1);
    pulse_start(27'h0);
    check("ovf cleared", 64'(overflow), 64'd0);

    // frame_start in the middle of a burst: burst completes, then restart at latched base
    clear_q();
    ctrl_en = 1'b1;
    pulse_start(27'h1000);
    push_words(32'd0, 128);
    wait_req(1'b1, 5, "mid req rise");
    repeat (5) tick();
    pulse_start(27'h2000);
    base_addr = 27'h5555;
    push_words(32'd500, 50);
    check("mid still req", 64'(wr_burst_req), 64'd1);
    wait_req(1'b0, 300, "mid req fall");
    repeat (2) tick();
    check("mid count", 64'(fifo_count), 64'd0);
    push_words(32'd2000, 128);
    repeat (200) tick();
    check("mid nbursts", 64'(addr_q.size()), 64'd2);
    if (addr_q.size() > 1) begin
      check("mid addr0", 64'(addr_q[0]), 64'h1000);
      check("mid addr1", 64'(addr_q[1]), 64'h2000);
    end
    check("mid nwords", 64'(rx_q.size()), 64'd256);
    for (int w = 0; w < 256 && w < rx_q.size(); w++) begin
      check($sformatf("mid data[%0d]", w), 64'(rx_q[w]),
            64'((w < 128) ? 32'(w) : 32'd2000 + 32'(w - 128)));
    end

    // asynchronous reset while a burst is requested
    clear_q();
    ctrl_en = 1'b0;
    pulse_start(27'h0);
    push_words(32'd7000, 128);
    wait_req(1'b1, 5, "arst req rise");
    #3;
    rst_n = 1'b0;
    #1;
    check("arst req",   64'(wr_burst_req),  64'd0);
    check("arst count", 64'(fifo_count),    64'd0);
    check("arst busy",  64'(busy),          64'd0);
    check("arst len",   64'(wr_burst_len),  64'd0);
    check("arst addr",  64'(wr_burst_addr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
